// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampled UART receiver with 3-sample majority vote, optional
//            parity and stop-bit checking. Optional RX_INPUT_SYNC_EN adds a
//            2-flop input synchronizer (+2 CLK latency).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int c_BCNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    logic [PRESCALE_W-1:0]   r_edge_cnt;
    logic [c_BCNT_W-1:0]     r_bit_cnt;
    logic [PRESCALE_W-1:0]   r_ps;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_fail;
    logic [2:0]              r_smp;
    logic [DATA_WIDTH-1:0]   r_shift;

    logic                    w_rx;
    logic [PRESCALE_W-1:0]   w_ps_in;
    logic [PRESCALE_W-1:0]   w_half;
    logic                    w_last;
    logic                    w_vote_pt;
    logic                    w_vote;
    logic                    w_par_exp;

`ifdef RX_INPUT_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_in};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = rx_in;
`endif

    // Unsupported (small or odd) prescale values fall back to 8x oversampling.
    assign w_ps_in   = ((prescale < PRESCALE_W'(6)) || prescale[0]) ? PRESCALE_W'(8) : prescale;
    assign w_half    = r_ps >> 1;
    assign w_last    = (r_edge_cnt == r_ps - PRESCALE_W'(1));
    assign w_vote_pt = (r_edge_cnt == w_half + PRESCALE_W'(2));
    assign w_vote    = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
    assign w_par_exp = (^r_shift) ^ r_par_typ;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ps       <= PRESCALE_W'(8);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_fail <= 1'b0;
            r_smp      <= 3'b111;
            r_shift    <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (r_state != S_IDLE) begin
                r_edge_cnt <= w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
                if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_smp[0] <= w_rx;
                if (r_edge_cnt == w_half)                  r_smp[1] <= w_rx;
                if (r_edge_cnt == w_half + PRESCALE_W'(1)) r_smp[2] <= w_rx;
            end

            case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= '0;
                    if (!w_rx) begin
                        r_state    <= S_START;
                        r_ps       <= w_ps_in;
                        r_par_en   <= par_en;
                        r_par_typ  <= par_typ;
                        r_par_fail <= 1'b0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_state <= w_vote ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_BCNT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_last) begin
                        if (w_vote != w_par_exp) r_par_fail <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leaving mid-bit lets IDLE catch a start edge that follows with no idle gap.
                    if (w_vote_pt) begin
                        r_state    <= S_IDLE;
                        r_edge_cnt <= '0;
                        if (!w_vote) begin
                            stp_err <= 1'b1;
                        end else if (r_par_fail) begin
                            par_err <= 1'b1;
                        end else begin
                            p_data     <= r_shift;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int         n_dv = 0, n_pe = 0, n_se = 0;
    int         last_cyc = 0, drop_cyc = 0;
    logic [7:0] first_data = '0, last_data = '0;

    // Pulse monitor: each high sample is one cycle of pulse.
    always @(negedge CLK) begin
        if (data_valid) begin
            if (n_dv == 0) first_data = p_data;
            last_data = p_data;
            n_dv++;
            last_cyc = cyc;
        end
        if (par_err) begin
            n_pe++;
            last_cyc = cyc;
        end
        if (stp_err) begin
            n_se++;
            last_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_dv = 0; n_pe = 0; n_se = 0;
        first_data = '0; last_data = '0;
    endtask

    task automatic drive_bit(input logic b, input int ps);
        rx_in = b;
        repeat (ps) @(negedge CLK);
    endtask

    // Called on a negedge; returns on the negedge that ends the stop bit.
    task automatic send_frame(input logic [7:0] d, input int ps, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        drop_cyc = cyc;
        drive_bit(1'b0, ps);
        for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
        if (with_par) drive_bit(par_bit, ps);
        drive_bit(stop_bit, ps);
    endtask

    // Frame cycle 0 is the first START cycle, one edge after the line drops;
    // the registered pulse is sampled one cycle after the vote cycle.
    function automatic int latency();
        return last_cyc - drop_cyc - 2;
    endfunction

    initial begin
        RST      = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset p_data",     32'(p_data),     32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset par_err",    32'(par_err),    32'h0);
        check("reset stp_err",    32'(stp_err),    32'h0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // 8x, no parity, 0xA5
        clear_mon();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check("a5 dv count", 32'(n_dv), 32'd1);
        check("a5 p_data",   32'(last_data), 32'hA5);
        check("a5 latency",  32'(latency()), 32'd78);
        check("a5 par_err",  32'(n_pe), 32'd0);
        check("a5 stp_err",  32'(n_se), 32'd0);

        // 16x, even parity, 0x3C has even weight so parity bit 0 is good
        clear_mon();
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check("3c dv count", 32'(n_dv), 32'd1);
        check("3c p_data",   32'(last_data), 32'h3C);
        check("3c latency",  32'(latency()), 32'd170);

        // Same frame with a wrong parity bit; change config mid-frame to prove it is latched
        clear_mon();
        fork
            send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
            begin
                repeat (40) @(negedge CLK);
                prescale = 6'd8; par_en = 1'b0;
            end
        join
        repeat (10) @(negedge CLK);
        check("3c bad par_err",  32'(n_pe), 32'd1);
        check("3c bad dv",       32'(n_dv), 32'd0);
        check("3c bad latency",  32'(latency()), 32'd170);
        check("3c bad p_data hold", 32'(p_data), 32'h3C);

        // 32x, stop bit forced low
        clear_mon();
        prescale = 6'd32; par_en = 1'b0;
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b1;
        repeat (64) @(negedge CLK);
        check("81 stp_err",  32'(n_se), 32'd1);
        check("81 par_err",  32'(n_pe), 32'd0);
        check("81 dv",       32'(n_dv), 32'd0);
        check("81 latency",  32'(latency()), 32'd306);
        check("81 p_data hold", 32'(p_data), 32'h3C);
        clear_mon();
        send_frame(8'h7E, 32, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check("7e dv count", 32'(n_dv), 32'd1);
        check("7e p_data",   32'(last_data), 32'h7E);
        check("7e errs",     32'(n_pe + n_se), 32'd0);

        // Start glitch at 8x
        clear_mon();
        prescale = 6'd8;
        rx_in = 1'b0;
        repeat (3) @(negedge CLK);
        rx_in = 1'b1;
        repeat (20) @(negedge CLK);
        check("glitch pulses", 32'(n_dv + n_pe + n_se), 32'd0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check("55 dv count", 32'(n_dv), 32'd1);
        check("55 p_data",   32'(last_data), 32'h55);

        // Back-to-back with zero idle
        clear_mon();
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check("b2b dv count", 32'(n_dv), 32'd2);
        check("b2b first",    32'(first_data), 32'h12);
        check("b2b second",   32'(last_data), 32'h34);
        check("b2b errs",     32'(n_pe + n_se), 32'd0);

        // Reset in the middle of the data bits
        clear_mon();
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 4);
        RST = 1'b0;
        #1;
        check("midrst p_data", 32'(p_data), 32'h0);
        check("midrst outs",   32'({data_valid, par_err, stp_err}), 32'h0);
        rx_in = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (100) @(negedge CLK);
        check("midrst pulses", 32'(n_dv + n_pe + n_se), 32'd0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check("c3 dv count", 32'(n_dv), 32'd1);
        check("c3 p_data",   32'(last_data), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
